risc_mem_arb: RTL and testbench
===============================

RISC_MEM_ARB -- requirements
Module: risc_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MEM_LAT, default 1, legal 1..7, cycles from memory command to valid i_mem_rdata.
REQ-004 Port i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port i_if_req  in  1  instruction-fetch read request.
REQ-007 Port i_if_addr  in  ADDR_W  fetch address.
REQ-008 Port o_if_gnt  out  1  fetch request accepted, one-cycle pulse.
REQ-009 Port o_if_rvalid  out  1  o_if_rdata valid, one-cycle pulse.
REQ-010 Port o_if_rdata  out  DATA_W  fetched instruction word.
REQ-011 Port i_d_req  in  1  data load/store request.
REQ-012 Port i_d_we  in  1  1 = store, 0 = load.
REQ-013 Port i_d_addr  in  ADDR_W  data address.
REQ-014 Port i_d_wdata  in  DATA_W  store data.
REQ-015 Port o_d_gnt / o_d_rvalid / o_d_rdata  out  1/1/DATA_W  data-port equivalents of REQ-008..010.
REQ-016 Port o_mem_en / o_mem_we  out  1/1  single-port memory command strobe and write enable.
REQ-017 Port o_mem_addr / o_mem_wdata  out  ADDR_W/DATA_W  memory address and write data.
REQ-018 Port i_mem_rdata  in  DATA_W  memory read data.
REQ-019 Port o_busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ACCESS, WAIT; ACCESS and WAIT return to IDLE only as listed below.
REQ-021 Requests are sampled only in IDLE; with any request pending, next state is ACCESS and the winner is latched.
REQ-022 In ACCESS: the winner's gnt is high, o_mem_en = 1, and o_mem_addr/o_mem_we/o_mem_wdata are registered copies of the winner's inputs captured at the IDLE->ACCESS edge; o_mem_we = 0 for fetch.
REQ-023 o_mem_en is high exactly one cycle per access; memory outputs are held stable outside ACCESS.
REQ-024 Store: ACCESS -> IDLE; no rvalid is generated.
REQ-025 Load or fetch: ACCESS -> WAIT; WAIT lasts MEM_LAT cycles (3-bit down-counter); i_mem_rdata is sampled on the final WAIT edge.
REQ-026 rvalid pulses the cycle after the final WAIT edge (state already IDLE), so rvalid occurs MEM_LAT+1 cycles after gnt; rdata holds until the next read completion on that port.
REQ-027 Requester holds req/addr/wdata until gnt; dropping req before gnt is legal and yields no access.
REQ-028 A request asserted in the same cycle rvalid is issued is eligible for arbitration in that cycle (back-to-back IDLE).
REQ-029 Fixed priority on simultaneous requests: data port wins.
REQ-030 o_busy = (state != IDLE), registered.

Reset
REQ-031 Assertion of i_rst_n low immediately forces IDLE, clears the latency counter, and drives all outputs to 0.
REQ-032 Reset mid-access aborts it; no gnt or rvalid for the aborted access appears after release.
REQ-033 Round-robin pointer (REQ-034) resets to "data last granted", so fetch wins the first tie.

Configuration
REQ-034 Macro RISC_ARB_ROUND_ROBIN_EN defined: ties go to the port not granted most recently; pointer updates on every grant.
REQ-035 Macro undefined: fixed priority per REQ-029, no pointer register present.

Structure
REQ-036 Package risc_arb_pkg holds the state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2) and port IDs (PORT_IF=1'b0, PORT_D=1'b1).
REQ-037 Sub-module risc_arb_pick: combinational winner selection from two requests plus optional last-grant pointer.

Verification
REQ-038 Fetch only, addr 0x0010, memory returns 0xA5A5, MEM_LAT=1 -> o_if_gnt at cycle G, o_mem_en one cycle at G, o_if_rvalid at G+2 with 0xA5A5.
REQ-039 Store addr 0x0200 data 0x1234 -> o_mem_en=1, o_mem_we=1, addr/data match for one cycle, no o_d_rvalid, o_busy low next cycle.
REQ-040 Both requesting continuously, macro undefined -> data granted every access, fetch starved; macro defined -> grants alternate IF, D, IF, D.
REQ-041 MEM_LAT=3 load from 0x0044 -> o_d_rvalid exactly 4 cycles after o_d_gnt; o_busy high for 4 cycles.
REQ-042 i_rst_n pulsed low during WAIT -> all outputs 0 at once, no rvalid after release, next request serviced normally.

Source files
------------

// File: rtl/risc_arb_pkg.sv
// risc_arb_pkg: shared state encoding and port IDs for the instruction/data memory arbiter.
package risc_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;
endpackage

// File: rtl/risc_arb_pick.sv
// risc_arb_pick: combinational winner selection between fetch and data requests.
module risc_arb_pick import risc_arb_pkg::*; #(
  parameter bit RR = 1'b0
) (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_last,
  output logic o_win
);
  // On a tie the data port wins unless rotation says fetch is due.
  assign o_win = i_d_req && (!i_if_req || !RR || i_last == PORT_IF);
endmodule

// File: rtl/risc_mem_arb.sv
// risc_mem_arb: arbitrates fetch and data ports onto one single-port memory.
// Define RISC_ARB_ROUND_ROBIN_EN for last-grant rotation on ties; default is fixed data priority.
module risc_mem_arb import risc_arb_pkg::*; #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);
  state_t              state_q, state_d;
  logic                win_q, win_d, we_q, we_d, busy_q, busy_d;
  logic                if_rv_q, if_rv_d, d_rv_q, d_rv_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                start, pick_w, last;

  assign start = state_q == IDLE && (i_if_req || i_d_req);

`ifdef RISC_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
  logic last_q, last_d;
  assign last_d = start ? pick_w : last_q;
  assign last   = last_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) last_q <= PORT_D;
    else last_q <= last_d;
`else
  localparam bit RR = 1'b0;
  assign last = PORT_D;
`endif

  risc_arb_pick #(.RR(RR)) u_pick (
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .i_last   (last),
    .o_win    (pick_w)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rv_d    = 1'b0;
    d_rv_d     = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (start) begin
      state_d = ACCESS;
      win_d   = pick_w;
      we_d    = pick_w && i_d_we;
      addr_d  = pick_w ? i_d_addr : i_if_addr;
      wdata_d = pick_w ? i_d_wdata : wdata_q;
    end
    if (state_q == ACCESS) begin
      state_d = we_q ? IDLE : WAIT;
      cnt_d   = 3'(MEM_LAT);
    end
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d    = IDLE;
        if_rv_d    = win_q == PORT_IF;
        d_rv_d     = win_q == PORT_D;
        if_rdata_d = win_q == PORT_IF ? i_mem_rdata : if_rdata_q;
        d_rdata_d  = win_q == PORT_D ? i_mem_rdata : d_rdata_q;
      end
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q    <= IDLE;
      win_q      <= PORT_IF;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rv_q    <= 1'b0;
      d_rv_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rv_q    <= if_rv_d;
      d_rv_q     <= d_rv_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end

  assign o_if_gnt    = state_q == ACCESS && win_q == PORT_IF;
  assign o_d_gnt     = state_q == ACCESS && win_q == PORT_D;
  assign o_mem_en    = state_q == ACCESS;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_if_rvalid = if_rv_q;
  assign o_d_rvalid  = d_rv_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_risc_mem_arb.sv
// tb_risc_mem_arb: randomized self-checking bench; dut uses MEM_LAT=1, dut3 uses MEM_LAT=3 (data port only).
module tb_risc_mem_arb;
  localparam int LAT = 1;
`ifdef RISC_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic d3_req = 0;
  logic [15:0] d3_addr = 0;
  logic if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  int checks = 0, errors = 0;
  bit last_d = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return a == 16'h0010 ? 16'hA5A5 : (a ^ 16'h3C5A) + 16'h0123;
  endfunction
  assign mem_rdata  = rd(mem_addr);
  assign mem_rdata3 = rd(mem_addr3);

  risc_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy));

  risc_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(1'b0), .i_if_addr(16'h0), .o_if_gnt(if_gnt3), .o_if_rvalid(if_rvalid3), .o_if_rdata(if_rdata3),
    .i_d_req(d3_req), .i_d_we(1'b0), .i_d_addr(d3_addr), .i_d_wdata(16'h0),
    .o_d_gnt(d_gnt3), .o_d_rvalid(d_rvalid3), .o_d_rdata(d_rdata3),
    .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
    .i_mem_rdata(mem_rdata3), .o_busy(busy3));

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    rst_n = 1'b1;
    last_d = 1'b1;
  endtask

  task automatic run_txn(input bit ifr, input bit dr, input bit we,
                         input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
    bit w;
    int n;
    logic [15:0] ea;
    w  = dr && (!ifr || !RR || !last_d);
    ea = w ? da : ia;
    @(negedge clk);
    if_req = ifr; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    @(negedge clk);
    checks++;
    if (if_gnt !== !w || d_gnt !== w || mem_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL grant got if=%b d=%b en=%b busy=%b want d=%b", if_gnt, d_gnt, mem_en, busy, w);
    end
    checks++;
    if (mem_addr !== ea || mem_we !== (w && we) || (w && we && mem_wdata !== wd)) begin
      errors++; $display("FAIL mem_cmd got a=%h we=%b wd=%h want a=%h we=%b wd=%h", mem_addr, mem_we, mem_wdata, ea, w && we, wd);
    end
    last_d = w;
    if_req = 0; d_req = 0;
    if (w && we) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || d_rvalid !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL store_end got busy=%b rvalid=%b en=%b want 0", busy, d_rvalid, mem_en);
      end
    end else begin
      n = 0;
      while (!(w ? d_rvalid : if_rvalid) && n < 10) begin
        @(negedge clk); n++;
      end
      checks++;
      if (n != LAT + 1) begin
        errors++; $display("FAIL rvalid_latency got %0d want %0d", n, LAT + 1);
      end
      checks++;
      if ((w ? d_rdata : if_rdata) !== rd(ea) || busy !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL rdata got %h busy=%b want %h", w ? d_rdata : if_rdata, busy, rd(ea));
      end
    end
  endtask

  task automatic test_fetch;
    run_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);
  endtask

  task automatic test_store;
    run_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200, 16'h1234);
  endtask

  task automatic test_priority;
    int n;
    bit e;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    last_d = 1'b1;
    if_req = 1; if_addr = 16'h0100; d_req = 1; d_we = 0; d_addr = 16'h0300;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!if_gnt && !d_gnt && n < 10) begin
        @(negedge clk); n++;
      end
      e = RR ? bit'(k % 2) : 1'b1;
      checks++;
      if (n >= 10 || d_gnt !== e || if_gnt !== !e) begin
        errors++; $display("FAIL tie_grant_%0d got if=%b d=%b want d=%b", k, if_gnt, d_gnt, e);
      end
      @(negedge clk);
    end
    if_req = 0; d_req = 0;
    last_d = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk); d3_req = 1; d3_addr = 16'h0080;
    n = 0;
    while (!d_gnt3 && n < 10) begin
      @(negedge clk); n++;
    end
    d3_req = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_gnt3, d_rvalid3, mem_en3, busy3, mem_addr3} !== 20'h0 || n >= 10) begin
      errors++; $display("FAIL reset_mid got gnt=%b rv=%b en=%b busy=%b a=%h want 0", d_gnt3, d_rvalid3, mem_en3, busy3, mem_addr3);
    end
    @(negedge clk); rst_n = 1'b1;
    last_d = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_rvalid3 || d_gnt3 || busy3) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL aborted_activity got %0d cycles want 0", n);
    end
  endtask

  task automatic test_lat3;
    int n, b;
    @(negedge clk); d3_req = 1; d3_addr = 16'h0044;
    n = 0;
    while (!d_gnt3 && n < 10) begin
      @(negedge clk); n++;
    end
    d3_req = 0;
    checks++;
    if (n >= 10 || mem_addr3 !== 16'h0044 || mem_en3 !== 1'b1) begin
      errors++; $display("FAIL lat3_gnt got a=%h en=%b want a=0044 en=1", mem_addr3, mem_en3);
    end
    n = 0; b = 0;
    while (!d_rvalid3 && n < 10) begin
      if (busy3) b++;
      @(negedge clk); n++;
    end
    checks++;
    if (n != 4 || b != 4) begin
      errors++; $display("FAIL lat3_timing got rvalid=%0d busy=%0d want 4 4", n, b);
    end
    checks++;
    if (d_rdata3 !== rd(16'h0044)) begin
      errors++; $display("FAIL lat3_rdata got %h want %h", d_rdata3, rd(16'h0044));
    end
  endtask

  task automatic test_random;
    int s;
    for (int k = 0; k < 30; k++) begin
      s = $urandom_range(1, 3);
      run_txn(s[0], s[1], 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store;
    test_priority;
    test_reset_mid;
    test_lat3;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
